// File: rtl/req_conditioner_pkg.sv
// Shared types for the two-channel button conditioner: debounce FSM state
// encoding and the press-order codes reported on first_out.
package req_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } deb_state_e;

  typedef enum logic [1:0] {
    FIRST_NONE = 2'b00,
    FIRST_P1   = 2'b01,
    FIRST_P2   = 2'b10,
    FIRST_TIE  = 2'b11
  } first_e;

  // Maps the two same-cycle press pulses onto a press-order code.
  function automatic first_e first_code(input logic p1, input logic p2);
    first_e code;
    case ({p2, p1})
      2'b01:   code = FIRST_P1;
      2'b10:   code = FIRST_P2;
      2'b11:   code = FIRST_TIE;
      default: code = FIRST_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/req_conditioner_if.sv
// Bundle of raw button inputs and conditioned outputs between the pads/bench
// (master) and the conditioner (slave).
interface req_conditioner_if;

  logic       req1_in;
  logic       req2_in;
  logic       req1_out;
  logic       req2_out;
  logic       req1_pulse_out;
  logic       req2_pulse_out;
  logic [1:0] first_out;

  modport master (
    output req1_in,
    output req2_in,
    input  req1_out,
    input  req2_out,
    input  req1_pulse_out,
    input  req2_pulse_out,
    input  first_out
  );

  modport slave (
    input  req1_in,
    input  req2_in,
    output req1_out,
    output req2_out,
    output req1_pulse_out,
    output req2_pulse_out,
    output first_out
  );

endinterface

// File: rtl/req_conditioner_debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with stable-cycle
// counter, registered level and single-cycle press pulse.
module debounce_channel
  import req_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 20
) (
  input  logic clk,
  input  logic rst_in,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             sync1_q;
  logic             sync2_q;
  logic             sync_x;
  deb_state_e       state_q;
  deb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_x = sync2_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= RELEASED;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // A pending state falls back as soon as the input disagrees once; it only
  // commits after DEBOUNCE_COUNT further agreeing cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (sync_x) begin
          state_d = PRESS_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_PENDING: begin
        if (!sync_x) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync_x) begin
          state_d = RELEASE_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_PENDING: begin
        if (sync_x) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    if (state_q == PRESS_PENDING && sync_x && cnt_q == CNT_MAX) begin
      level_d = 1'b1;
      pulse_d = 1'b1;
    end else if (state_q == RELEASE_PENDING && !sync_x && cnt_q == CNT_MAX) begin
      level_d = 1'b0;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/req_conditioner.sv
// Two-channel button conditioner feeding the arbiter core: debounced levels,
// press pulses, and a latched record of which player pressed first.
module req_conditioner
  import req_conditioner_pkg::*;
#(
  parameter int CLOCK_FREQ     = 1000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int DEBOUNCE_COUNT = CLOCK_FREQ * DEBOUNCE_MS / 1000
) (
  input  logic              clk,
  input  logic              rst_in,
  req_conditioner_if.slave  bus
);

  logic   level1;
  logic   level2;
  logic   pulse1;
  logic   pulse2;
  first_e first_q;
  first_e first_d;

  debounce_channel #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_ch1 (
    .clk     (clk),
    .rst_in  (rst_in),
    .raw_i   (bus.req1_in),
    .level_o (level1),
    .pulse_o (pulse1)
  );

  debounce_channel #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_ch2 (
    .clk     (clk),
    .rst_in  (rst_in),
    .raw_i   (bus.req2_in),
    .level_o (level2),
    .pulse_o (pulse2)
  );

  // Clearing wins over capture; a pulse implies its level is high, so the
  // two cannot actually coincide.
  always_comb begin
    first_d = first_q;
    if (!level1 && !level2) begin
      first_d = FIRST_NONE;
    end else if (first_q == FIRST_NONE) begin
      first_d = first_code(pulse1, pulse2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      first_q <= FIRST_NONE;
    end else begin
      first_q <= first_d;
    end
  end

  assign bus.req1_out       = level1;
  assign bus.req2_out       = level2;
  assign bus.req1_pulse_out = pulse1;
  assign bus.req2_pulse_out = pulse2;
  assign bus.first_out      = first_q;

endmodule

// File: tb/tb_req_conditioner.sv
// Self-checking bench for req_conditioner with DEBOUNCE_COUNT=4: directed
// scenarios plus randomized button activity against a run-length model.
module tb_req_conditioner;
  import req_conditioner_pkg::*;

  localparam int DC = 4;

  logic clk;
  logic rst_in;
  int   checks;
  int   errors;

  req_conditioner_if bus();

  req_conditioner #(
    .CLOCK_FREQ    (1000),
    .DEBOUNCE_MS   (4),
    .DEBOUNCE_COUNT(DC)
  ) dut (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once the synchronized input has disagreed
  // with it for DC+1 consecutive cycles.
  logic       mS1[2];
  logic       mS2[2];
  logic       mLevel[2];
  logic       mPulse[2];
  int         mRun[2];
  logic [1:0] mFirst;

  task automatic step();
    logic       raw[2];
    logic       nS1[2];
    logic       nS2[2];
    logic       nLevel[2];
    logic       nPulse[2];
    int         nRun[2];
    logic [1:0] nFirst;
    raw[0] = bus.req1_in;
    raw[1] = bus.req2_in;
    nFirst = mFirst;
    if (!mLevel[0] && !mLevel[1]) nFirst = 2'b00;
    else if (mFirst == 2'b00) nFirst = {mPulse[1], mPulse[0]};
    for (int ch = 0; ch < 2; ch++) begin
      nS1[ch] = raw[ch];
      nS2[ch] = mS1[ch];
      nLevel[ch] = mLevel[ch];
      nPulse[ch] = 1'b0;
      nRun[ch] = 0;
      if (mS2[ch] != mLevel[ch]) begin
        if (mRun[ch] + 1 == DC + 1) begin
          nLevel[ch] = mS2[ch];
          nPulse[ch] = mS2[ch];
        end else begin
          nRun[ch] = mRun[ch] + 1;
        end
      end
      if (rst_in) begin
        nS1[ch] = 1'b0; nS2[ch] = 1'b0; nLevel[ch] = 1'b0;
        nPulse[ch] = 1'b0; nRun[ch] = 0;
      end
    end
    if (rst_in) nFirst = 2'b00;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      mS1[ch] = nS1[ch]; mS2[ch] = nS2[ch]; mLevel[ch] = nLevel[ch];
      mPulse[ch] = nPulse[ch]; mRun[ch] = nRun[ch];
    end
    mFirst = nFirst;
  endtask

  task automatic settle();
    bus.req1_in = 1'b0;
    bus.req2_in = 1'b0;
    rst_in = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_in = 1'b1;
    bus.req1_in = 1'b1;
    bus.req2_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {bus.req1_out, bus.req2_out, bus.req1_pulse_out, bus.req2_pulse_out, bus.first_out};
      checks++;
      if (got !== 6'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d got %b expected 000000", i, got);
      end
    end
    rst_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (bus.req1_out !== (i >= 7) || bus.req1_pulse_out !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL reset_redetect step %0d got level %b pulse %b expected level %b pulse %b",
                 i, bus.req1_out, bus.req1_pulse_out, i >= 7, i == 7);
      end
    end
    checks++;
    if (bus.first_out !== FIRST_TIE) begin
      errors++;
      $display("[TB] FAIL reset_tie_first got %b expected 11", bus.first_out);
    end
    settle();
  endtask

  task automatic test_clean_press();
    logic [1:0] expFirst;
    bus.req1_in = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      expFirst = (i >= 8) ? FIRST_P1 : FIRST_NONE;
      checks++;
      if (bus.req1_out !== (i >= 7) || bus.req1_pulse_out !== (i == 7) ||
          bus.req2_out !== 1'b0 || bus.first_out !== expFirst) begin
        errors++;
        $display("[TB] FAIL clean_press step %0d got level %b pulse %b lvl2 %b first %b expected %b %b 0 %b",
                 i, bus.req1_out, bus.req1_pulse_out, bus.req2_out, bus.first_out,
                 i >= 7, i == 7, expFirst);
      end
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic [1:0] expFirst;
    pat = 5'b01101;
    for (int i = 1; i <= 14; i++) begin
      bus.req2_in = (i <= 5) ? pat[i-1] : 1'b1;
      step();
      expFirst = (i >= 13) ? FIRST_P2 : FIRST_NONE;
      checks++;
      if (bus.req2_pulse_out !== (i == 12) || bus.req2_out !== (i >= 12) ||
          bus.first_out !== expFirst) begin
        errors++;
        $display("[TB] FAIL bounce step %0d got level %b pulse %b first %b expected %b %b %b",
                 i, bus.req2_out, bus.req2_pulse_out, bus.first_out, i >= 12, i == 12, expFirst);
      end
    end
    settle();
  endtask

  task automatic test_tie();
    bus.req1_in = 1'b1;
    bus.req2_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (bus.req1_pulse_out !== (i == 7) || bus.req2_pulse_out !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL tie_pulses step %0d got %b%b expected %b%b",
                 i, bus.req1_pulse_out, bus.req2_pulse_out, i == 7, i == 7);
      end
    end
    checks++;
    if (bus.first_out !== FIRST_TIE) begin
      errors++;
      $display("[TB] FAIL tie_first got %b expected 11", bus.first_out);
    end
    settle();
  endtask

  task automatic test_order_clear();
    logic [1:0] expFirst;
    bus.req2_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) bus.req1_in = 1'b1;
      step();
      expFirst = (i >= 8) ? FIRST_P2 : FIRST_NONE;
      checks++;
      if (bus.first_out !== expFirst || bus.req1_pulse_out !== (i == 10)) begin
        errors++;
        $display("[TB] FAIL order step %0d got first %b p1 %b expected %b %b",
                 i, bus.first_out, bus.req1_pulse_out, expFirst, i == 10);
      end
    end
    bus.req1_in = 1'b0;
    bus.req2_in = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      expFirst = (j >= 8) ? FIRST_NONE : FIRST_P2;
      checks++;
      if (bus.first_out !== expFirst || bus.req1_out !== (j < 7) || bus.req2_out !== (j < 7)) begin
        errors++;
        $display("[TB] FAIL clear step %0d got first %b levels %b%b expected %b %b%b",
                 j, bus.first_out, bus.req1_out, bus.req2_out, expFirst, j < 7, j < 7);
      end
    end
    settle();
  endtask

  task automatic test_mid_reset();
    bus.req1_in = 1'b1;
    repeat (4) step();
    checks++;
    if (dut.u_ch1.state_q !== PRESS_PENDING || dut.u_ch1.cnt_q !== 3'd2) begin
      errors++;
      $display("[TB] FAIL midreset_pre got state %0d cnt %0d expected 1 2",
               dut.u_ch1.state_q, dut.u_ch1.cnt_q);
    end
    rst_in = 1'b1;
    step();
    checks++;
    if (dut.u_ch1.state_q !== RELEASED || dut.u_ch1.cnt_q !== 3'd0 ||
        bus.req1_pulse_out !== 1'b0 || bus.req1_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_post got state %0d cnt %0d pulse %b level %b expected 0 0 0 0",
               dut.u_ch1.state_q, dut.u_ch1.cnt_q, bus.req1_pulse_out, bus.req1_out);
    end
    rst_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (bus.req1_pulse_out !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL midreset_latency step %0d got pulse %b expected %b",
                 i, bus.req1_pulse_out, i == 7);
      end
    end
    settle();
  endtask

  task automatic test_random();
    int         hold[2];
    logic [5:0] got;
    logic [5:0] exp;
    hold[0] = 1;
    hold[1] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        hold[ch]--;
        if (hold[ch] == 0) begin
          hold[ch] = int'($urandom_range(1, 10));
          if (ch == 0) bus.req1_in = ~bus.req1_in;
          else bus.req2_in = ~bus.req2_in;
        end
      end
      rst_in = ($urandom_range(0, 299) == 0);
      step();
      got = {bus.req1_out, bus.req2_out, bus.req1_pulse_out, bus.req2_pulse_out, bus.first_out};
      exp = {mLevel[0], mLevel[1], mPulse[0], mPulse[1], mFirst};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL random_model cycle %0d got %b expected %b (lvl1 lvl2 p1 p2 first)",
                 c, got, exp);
      end
    end
    rst_in = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_in = 1'b1;
    bus.req1_in = 1'b0;
    bus.req2_in = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      mS1[ch] = 1'b0; mS2[ch] = 1'b0; mLevel[ch] = 1'b0; mPulse[ch] = 1'b0; mRun[ch] = 0;
    end
    mFirst = 2'b00;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_tie();
    test_order_clear();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
